// File: rtl/axi_dma_wr_burst_if.sv
// Write-DMA bus bundle: the input beat stream plus the AXI4 AW/W/B channels.
// The master modport is the DMA side; the slave modport is the stream source/interconnect side.
interface axi_dma_wr_burst_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 64,
    parameter int AXI_WIDTH_ID = 4
);
    localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;

    logic [AXI_WIDTH_DA-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;

    logic                    M_AWVALID;
    logic                    M_AWREADY;
    logic [AXI_WIDTH_AD-1:0] M_AWADDR;
    logic [7:0]              M_AWLEN;
    logic [2:0]              M_AWSIZE;
    logic [1:0]              M_AWBURST;
    logic [AXI_WIDTH_ID-1:0] M_AWID;

    logic                    M_WVALID;
    logic                    M_WREADY;
    logic [AXI_WIDTH_DA-1:0] M_WDATA;
    logic [AXI_WIDTH_DS-1:0] M_WSTRB;
    logic                    M_WLAST;

    logic                    M_BVALID;
    logic                    M_BREADY;
    logic [1:0]              M_BRESP;

    modport master (
        input  s_data, s_valid, M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
        output s_ready, M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
               M_WVALID, M_WDATA, M_WSTRB, M_WLAST, M_BREADY
    );

    modport slave (
        output s_data, s_valid, M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
        input  s_ready, M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
               M_WVALID, M_WDATA, M_WSTRB, M_WLAST, M_BREADY
    );
endinterface

// File: rtl/axi_dma_wr_burst.sv
// AXI4 write-DMA master: splits a job into INCR bursts (max length, 4 KB safe), one outstanding; first AWVALID 2 cycles after start.
// W beats pass straight through from the stream, so s_valid/M_WREADY stalls propagate combinationally with no bubbles.
module axi_dma_wr_burst #(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 64,
    parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
    parameter int AXI_WIDTH_ID = 4,
    parameter int MAX_BURST    = 16,
    parameter int AXI_ID       = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_dma,
    input  logic [AXI_WIDTH_AD-1:0] start_addr,
    input  logic [BITS_TRANS-1:0]   num_trans,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [7:0]              err_cnt_o,
    axi_dma_wr_burst_if.master      bus
);
    localparam int SZ = $clog2(AXI_WIDTH_DS);

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP} state_t;

    state_t                  state, state_nxt;
    logic [AXI_WIDTH_AD-1:0] addr;
    logic [BITS_TRANS-1:0]   rem;
    logic [8:0]              len;
    logic [8:0]              beat_cnt;
    logic [AXI_WIDTH_AD-1:0] awaddr;
    logic [7:0]              awlen;
    logic [12:0]             bnd_beats;
    logic [8:0]              len_calc;
    logic                    beat_fire;
    logic                    last_beat;

    // Beats left before the next 4 KB page, then the smallest of the three limits.
    always_comb begin
        bnd_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
        len_calc  = 9'(MAX_BURST);
        if (32'(rem) < 32'(len_calc))
            len_calc = 9'(rem);
        if (32'(bnd_beats) < 32'(len_calc))
            len_calc = 9'(bnd_beats);
    end

    assign beat_fire = (state == DATA) && bus.s_valid && bus.M_WREADY;
    assign last_beat = (beat_cnt == len - 9'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_dma && !done_o) state_nxt = CALC;
            CALC: state_nxt = (rem == '0) ? IDLE : ADDR;
            ADDR: if (bus.M_AWREADY) state_nxt = DATA;
            DATA: if (beat_fire && last_beat) state_nxt = RESP;
            RESP: if (bus.M_BVALID) state_nxt = CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            len       <= '0;
            beat_cnt  <= '0;
            awaddr    <= '0;
            awlen     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_dma && !done_o) begin
                    addr      <= start_addr & ~AXI_WIDTH_AD'(AXI_WIDTH_DS - 1);
                    rem       <= num_trans;
                    err_o     <= 1'b0;
                    err_cnt_o <= '0;
                    busy_o    <= 1'b1;
                end
                CALC: if (rem == '0) begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                end else begin
                    len      <= len_calc;
                    awaddr   <= addr;
                    awlen    <= 8'(len_calc - 9'd1);
                    beat_cnt <= '0;
                end
                DATA: if (beat_fire) beat_cnt <= beat_cnt + 9'd1;
                RESP: if (bus.M_BVALID) begin
                    // A failed burst is only recorded; its data is already gone.
                    if (bus.M_BRESP != 2'b00) begin
                        err_o <= 1'b1;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                    end
                    addr <= addr + AXI_WIDTH_AD'({len, {SZ{1'b0}}});
                    rem  <= rem - BITS_TRANS'(len);
                end
                default: ;
            endcase
        end
    end

    assign bus.M_AWVALID = (state == ADDR);
    assign bus.M_AWADDR  = awaddr;
    assign bus.M_AWLEN   = awlen;
    assign bus.M_AWSIZE  = 3'(SZ);
    assign bus.M_AWBURST = 2'b01;
    assign bus.M_AWID    = AXI_WIDTH_ID'(AXI_ID);
    assign bus.M_WVALID  = (state == DATA) && bus.s_valid;
    assign bus.M_WDATA   = (state == DATA) ? bus.s_data : '0;
    assign bus.M_WSTRB   = (state == DATA) ? '1 : '0;
    assign bus.M_WLAST   = (state == DATA) && last_beat;
    assign bus.s_ready   = (state == DATA) && bus.M_WREADY;
    assign bus.M_BREADY  = (state == RESP);
endmodule

// File: tb/tb_axi_dma_wr_burst.sv
// Randomized bench for axi_dma_wr_burst: a burst-plan model and a per-cycle bus monitor.
module tb_axi_dma_wr_burst;
    localparam int AD = 32, DA = 64, DS = 8, IDW = 4, BT = 18, MB = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          start_dma;
    logic [AD-1:0] start_addr;
    logic [BT-1:0] num_trans;
    logic          busy_o, done_o, err_o;
    logic [7:0]    err_cnt_o;

    axi_dma_wr_burst_if #(.AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .AXI_WIDTH_ID(IDW)) bus ();

    axi_dma_wr_burst #(
        .BITS_TRANS(BT), .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .AXI_WIDTH_DS(DS),
        .AXI_WIDTH_ID(IDW), .MAX_BURST(MB), .AXI_ID(0)
    ) u_dut (
        .clk(clk), .rstn(rstn), .start_dma(start_dma), .start_addr(start_addr),
        .num_trans(num_trans), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_cnt_o(err_cnt_o), .bus(bus.master)
    );

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stimulus configuration, written by the main sequence.
    bit          gaps = 0;
    int          aw_delay = 0;
    logic [31:0] err_mask = 0;

    // Expected bursts for the current job.
    logic [AD-1:0] exp_addr_q[$];
    int            exp_len_q[$];

    // Monitor state.
    bit            in_data = 0, prev_aw_wait = 0, stream_take, b_take;
    int            cur_len = 0, beat = 0, b_pend = 0, b_idx = 0, aw_hold = 0;
    int            done_cnt = 0, beats = 0, err_seen = 0, first_aw_cyc = -1;
    logic [AD-1:0] prev_awaddr;
    logic [7:0]    prev_awlen;
    logic [31:0]   seq_tx = 0, seq_exp = 0;

    function automatic void plan(input logic [AD-1:0] a0, input int n);
        logic [AD-1:0] a;
        int rem, bnd, len;
        a = a0 & ~32'(DS - 1);
        rem = n;
        while (rem > 0) begin
            bnd = (4096 - int'(a[11:0])) / DS;
            len = MB;
            if (rem < len) len = rem;
            if (bnd < len) len = bnd;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(len);
            a = a + 32'(len * DS);
            rem = rem - len;
        end
    endfunction

    function automatic int nerr(input logic [31:0] mask, input int nb);
        int c = 0;
        for (int i = 0; i < nb && i < 32; i++) if (mask[i]) c++;
        return c;
    endfunction

    // Bus monitor and responder: check at negedge, drive #1 after posedge.
    initial begin
        bus.s_valid = 0; bus.s_data = '0; bus.M_AWREADY = 0; bus.M_WREADY = 0;
        bus.M_BVALID = 0; bus.M_BRESP = 2'b00;
        forever begin
            @(negedge clk);
            stream_take = 0;
            b_take = 0;
            if (!rstn) begin
                in_data = 0; b_pend = 0; prev_aw_wait = 0; aw_hold = 0;
                seq_tx = 0; seq_exp = 0;
                exp_addr_q.delete();
                exp_len_q.delete();
            end else begin
                if (start_dma && !busy_o && !done_o) begin
                    done_cnt = 0; beats = 0; err_seen = 0; b_idx = 0; first_aw_cyc = -1;
                end
                if (prev_aw_wait) begin
                    chk("aw_hold_valid", bus.M_AWVALID, 1);
                    chk("aw_hold_addr", bus.M_AWADDR, prev_awaddr);
                    chk("aw_hold_len", bus.M_AWLEN, prev_awlen);
                end
                if (in_data) begin
                    chk("wvalid_pass", bus.M_WVALID, bus.s_valid);
                    chk("s_ready_pass", bus.s_ready, bus.M_WREADY);
                    chk("wstrb", bus.M_WSTRB, 8'hFF);
                    if (bus.s_valid && bus.M_WREADY) begin
                        chk("wdata", bus.M_WDATA, bus.s_data);
                        chk("wdata_seq", bus.M_WDATA[63:32], seq_exp);
                        chk("wlast", bus.M_WLAST, beat == cur_len - 1);
                        seq_exp++;
                        beat++;
                        beats++;
                        stream_take = 1;
                        if (beat == cur_len) begin
                            in_data = 0;
                            b_pend++;
                        end
                    end
                end else begin
                    chk("wvalid_idle", bus.M_WVALID, 0);
                    chk("s_ready_idle", bus.s_ready, 0);
                end
                if (bus.M_AWVALID && first_aw_cyc < 0) first_aw_cyc = cyc;
                if (bus.M_AWVALID && bus.M_AWREADY) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("aw_unexpected", 1, 0);
                    end else begin
                        cur_len = exp_len_q.pop_front();
                        chk("awaddr", bus.M_AWADDR, exp_addr_q.pop_front());
                        chk("awlen", bus.M_AWLEN, 64'(cur_len - 1));
                        chk("awsize", bus.M_AWSIZE, 3);
                        chk("awburst", bus.M_AWBURST, 1);
                        chk("awid", bus.M_AWID, 0);
                        in_data = 1;
                        beat = 0;
                    end
                end
                if (bus.M_BVALID) chk("bready", bus.M_BREADY, 1);
                if (bus.M_BVALID && bus.M_BREADY) begin
                    b_take = 1;
                    if (bus.M_BRESP != 2'b00) err_seen++;
                    b_idx++;
                    b_pend--;
                end
                if (done_o) begin
                    done_cnt++;
                    chk("busy_at_done", busy_o, 0);
                end
                prev_aw_wait = bus.M_AWVALID && !bus.M_AWREADY;
                prev_awaddr = bus.M_AWADDR;
                prev_awlen = bus.M_AWLEN;
            end
            @(posedge clk);
            #1;
            if (!rstn) begin
                bus.s_valid = 0; bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0;
            end else begin
                if (!bus.s_valid || stream_take) begin
                    if (stream_take) seq_tx++;
                    bus.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.s_data = {seq_tx, $urandom};
                end
                bus.M_WREADY = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.M_AWVALID) begin
                    bus.M_AWREADY = (aw_hold >= aw_delay);
                    aw_hold++;
                end else begin
                    bus.M_AWREADY = 0;
                    aw_hold = 0;
                end
                if (b_take) bus.M_BVALID = 0;
                if (!bus.M_BVALID && b_pend > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
                    bus.M_BVALID = 1;
                    bus.M_BRESP = (b_idx < 32 && err_mask[b_idx]) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic start_job(input logic [AD-1:0] a, input int n, output int t0);
        @(posedge clk);
        #1;
        start_addr = a;
        num_trans = BT'(n);
        start_dma = 1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_dma = 0;
        @(negedge clk);
        chk("busy_after_start", busy_o, 1);
        chk("err_cleared_on_start", err_o, 0);
        chk("errcnt_cleared_on_start", err_cnt_o, 0);
    endtask

    task automatic wait_done(input string nm, input int n, input int exp_err, output int td);
        td = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_o) begin
                td = cyc;
                break;
            end
        end
        if (td < 0) chk({nm, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_beats"}, beats, n);
        chk({nm, "_bursts_left"}, exp_addr_q.size(), 0);
        chk({nm, "_err_o"}, err_o, exp_err != 0);
        chk({nm, "_err_cnt"}, err_cnt_o, exp_err);
        chk({nm, "_busy_end"}, busy_o, 0);
    endtask

    task automatic job(input string nm, input logic [AD-1:0] a, input int n);
        int t0, td, nb;
        plan(a, n);
        nb = exp_addr_q.size();
        start_job(a, n, t0);
        wait_done(nm, n, nerr(err_mask, nb), td);
    endtask

    initial begin
        int t0, td, nb, n;
        logic [AD-1:0] a;
        start_dma = 0; start_addr = '0; num_trans = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", bus.M_AWVALID, 0);
        chk("rst_awaddr", bus.M_AWADDR, 0);
        chk("rst_awlen", bus.M_AWLEN, 0);
        chk("rst_awsize", bus.M_AWSIZE, 3);
        chk("rst_awburst", bus.M_AWBURST, 1);
        chk("rst_awid", bus.M_AWID, 0);
        chk("rst_wvalid", bus.M_WVALID, 0);
        chk("rst_wlast", bus.M_WLAST, 0);
        chk("rst_bready", bus.M_BREADY, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_errcnt", err_cnt_o, 0);
        @(posedge clk);
        #1 rstn = 1;
        repeat (2) @(posedge clk);

        // Three bursts, always ready.
        plan(32'h1000, 40);
        chk("plan1_n", exp_addr_q.size(), 3);
        chk("plan1_a0", exp_addr_q[0], 32'h1000);
        chk("plan1_a1", exp_addr_q[1], 32'h1080);
        chk("plan1_a2", exp_addr_q[2], 32'h1100);
        chk("plan1_l0", exp_len_q[0], 16);
        chk("plan1_l2", exp_len_q[2], 8);
        start_job(32'h1000, 40, t0);
        wait_done("job1", 40, 0, td);
        chk("job1_first_aw", first_aw_cyc, t0 + 2);

        // 4 KB split.
        plan(32'h0FE0, 10);
        chk("plan2_n", exp_addr_q.size(), 2);
        chk("plan2_a1", exp_addr_q[1], 32'h1000);
        chk("plan2_l0", exp_len_q[0], 4);
        chk("plan2_l1", exp_len_q[1], 6);
        start_job(32'h0FE0, 10, t0);
        wait_done("job2", 10, 0, td);

        // Stalls on both sides, slow AWREADY.
        gaps = 1; aw_delay = 5;
        job("job3", 32'h1F40, 37);

        // SLVERR on first burst, then a clean job clears the flag.
        gaps = 0; aw_delay = 0; err_mask = 32'h1;
        plan(32'h2000, 20);
        chk("plan4_a1", exp_addr_q[1], 32'h2080);
        chk("plan4_l1", exp_len_q[1], 4);
        start_job(32'h2000, 20, t0);
        wait_done("job4", 20, 1, td);
        chk("job4_err_lit", err_cnt_o, 1);
        err_mask = 0;
        job("job5", 32'h3000, 4);

        // Empty job.
        start_job(32'h4000, 0, t0);
        wait_done("job0", 0, 0, td);
        chk("job0_done_lat", td, t0 + 2);
        chk("job0_no_aw", first_aw_cyc, -1);

        // Address wrap at the top of the space.
        job("jobwrap", 32'hFFFF_FFC0, 20);

        for (int j = 0; j < 6; j++) begin
            gaps = 1'($urandom_range(0, 1));
            aw_delay = $urandom_range(0, 3);
            err_mask = $urandom;
            a = ($urandom & 32'h0000_3FFF);
            n = $urandom_range(1, 60);
            job("jobrnd", a, n);
        end

        // Reset in the middle of the data phase.
        gaps = 0; aw_delay = 0; err_mask = 0;
        plan(32'h5000, 30);
        start_job(32'h5000, 30, t0);
        for (int i = 0; i < 500 && beats < 5; i++) @(negedge clk);
        chk("rstmid_reached_data", beats >= 5, 1);
        #2 rstn = 0;
        #1;
        chk("rstmid_awvalid", bus.M_AWVALID, 0);
        chk("rstmid_wvalid", bus.M_WVALID, 0);
        chk("rstmid_wlast", bus.M_WLAST, 0);
        chk("rstmid_bready", bus.M_BREADY, 0);
        chk("rstmid_s_ready", bus.s_ready, 0);
        chk("rstmid_awaddr", bus.M_AWADDR, 0);
        chk("rstmid_awburst", bus.M_AWBURST, 1);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_done", done_o, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        repeat (3) @(negedge clk);
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_idle_busy", busy_o, 0);
        job("job_after_rst", 32'h6000, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_dma_wr_burst.md
Name: axi_dma_wr_burst

Overview:
- Parametrised AXI4 write-DMA master; next generation of the output-feature-map write engine.
- Streams beats from a valid/ready source into DRAM as INCR bursts.
- Adds over the previous engine: configurable data width and max burst length; splitting of bursts at 4 KB boundaries; a backpressured input stream; a busy flag; a sticky error flag with an error count.
- Sits between the DMA controller and the AXI interconnect. One burst is outstanding at a time.

Parameters:
- BITS_TRANS, 18, width of num_trans (beats per job).
- AXI_WIDTH_AD, 32, address width.
- AXI_WIDTH_DA, 64, data width. Legal values: 32, 64, 128.
- AXI_WIDTH_DS, AXI_WIDTH_DA/8, strobe width.
- AXI_WIDTH_ID, 4, ID width.
- MAX_BURST, 16, maximum beats per burst. Power of two, 1..256.
- AXI_ID, 0, constant AWID value.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- start_dma, in, 1, job start pulse. Ignored while busy_o=1.
- start_addr, in, AXI_WIDTH_AD, job byte address. Low log2(AXI_WIDTH_DS) bits are forced to 0.
- num_trans, in, BITS_TRANS, number of beats in the job.
- busy_o, out, 1, high from start acceptance until done_o.
- done_o, out, 1, one-cycle job-complete pulse.
- err_o, out, 1, sticky: set by any non-OKAY BRESP, cleared by the next accepted start.
- err_cnt_o, out, 8, count of non-OKAY bursts in the current job. Saturates at 255.
- s_data, in, AXI_WIDTH_DA, input stream data.
- s_valid, in, 1, input stream valid.
- s_ready, out, 1, input stream ready.
- M_AWVALID, out, 1; M_AWREADY, in, 1; M_AWADDR, out, AXI_WIDTH_AD; M_AWLEN, out, 8; M_AWSIZE, out, 3; M_AWBURST, out, 2 (always 2'b01); M_AWID, out, AXI_WIDTH_ID (always AXI_ID).
- M_WVALID, out, 1; M_WREADY, in, 1; M_WDATA, out, AXI_WIDTH_DA; M_WSTRB, out, AXI_WIDTH_DS (all ones); M_WLAST, out, 1.
- M_BVALID, in, 1; M_BREADY, out, 1; M_BRESP, in, 2.

Behaviour:
- Reset values:
  - All outputs are 0, except M_AWBURST=2'b01, M_AWID=AXI_ID, and M_AWSIZE=log2(AXI_WIDTH_DS).
  - The FSM is in IDLE and all counters are 0.
  - Asserting reset mid-job aborts the job immediately. There is no done_o pulse, and no AXI signal stays asserted after reset.
- FSM states: IDLE, CALC, ADDR, DATA, RESP.
- IDLE:
  - On start_dma, latch addr, rem=num_trans, clear err_o and err_cnt_o, set busy_o, and go to CALC.
- CALC (1 cycle):
  - If rem==0: pulse done_o, clear busy_o, go to IDLE.
  - Otherwise compute len = min(MAX_BURST, rem, (4096 - addr[11:0]) >> log2(AXI_WIDTH_DS)).
  - Register M_AWADDR=addr and M_AWLEN=len-1, then go to ADDR.
- ADDR:
  - Hold M_AWVALID=1 with stable address and length until M_AWREADY.
  - On the handshake, drop M_AWVALID and go to DATA.
- DATA:
  - M_WVALID = s_valid, M_WDATA = s_data, s_ready = M_WREADY. These are combinational pass-throughs, so there is no bubble between beats.
  - A beat completes when s_valid && M_WREADY.
  - M_WLAST = (beat_cnt == len-1). After the last beat, go to RESP.
  - s_ready=0 in every state except DATA.
- RESP:
  - M_BREADY=1.
  - On M_BVALID: if BRESP != OKAY, set err_o and increment err_cnt_o (saturating).
  - Then addr += len*AXI_WIDTH_DS, rem -= len, go to CALC.
  - An erroring burst is not retried; the stream data has already been consumed.
- Timing: first M_AWVALID appears 2 cycles after the start_dma cycle. num_trans=0 produces done_o 2 cycles after start with no AXI activity.
- Bursts never cross a 4 KB boundary. Burst length is recomputed in CALC for every burst.
- Address arithmetic wraps modulo 2^AXI_WIDTH_AD. rem uses BITS_TRANS bits and never underflows, because len <= rem.
- start_dma arriving in the same cycle as done_o is ignored. Start is accepted only in IDLE.

Test Plan:
- DA=64, MAX_BURST=16, start_addr=0x1000, num_trans=40, always ready -> three bursts: AWADDR 0x1000/0x1080/0x1100 with AWLEN 15/15/7; 40 W beats with WLAST on beats 16, 32, 40; done_o pulses once; err_o=0.
- DA=64, start_addr=0x0FE0, num_trans=10 -> first burst AWADDR 0x0FE0, AWLEN=3 (4 KB split); second burst AWADDR 0x1000, AWLEN=5.
- Random s_valid and M_WREADY gaps, M_AWREADY delayed 5 cycles -> data order preserved, AWVALID and AWADDR stable while waiting, no beat lost or duplicated.
- num_trans=20, BRESP=SLVERR on the first burst -> err_o=1, err_cnt_o=1, the second burst still issued at the advanced address, done_o asserted; the next start clears err_o.
- num_trans=0 -> done_o 2 cycles after start; no M_AWVALID.
- Reset asserted mid-DATA, then released -> all outputs at reset values, busy_o=0; a new job of 8 beats completes correctly.
